// File: rtl/instr_feeder.sv
// Instruction issue unit: buffers {instr, data} pairs from a host and streams
// them into the processor one per cycle, honouring stall and stopping on HALT.
module instr_feeder #(
    parameter int         DEPTH  = 8,
    parameter logic [7:0] BUBBLE = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_wr_valid,
    output logic       o_wr_ready,
    input  logic [7:0] i_wr_instr,
    input  logic [7:0] i_wr_data,
    input  logic       i_start,
    input  logic       i_stall,
    output logic [7:0] o_instr_out,
    output logic [7:0] o_data_out,
    output logic       o_issue_valid,
    output logic       o_busy,
    output logic       o_halted,
    output logic [7:0] o_issued_count
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic [7:0]  r_instr_out, r_data_out, r_issued_count;
    logic        r_issue_valid;

    logic [7:0]  w_instr_next, w_data_next, w_count_next;
    logic        w_valid_next;
    logic        w_push, w_pop, w_full, w_empty;
    logic [AW:0] w_occupancy;
    logic [15:0] w_head;
    logic [1:0]  w_head_op;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_occupancy = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_occupancy == (AW + 1)'(DEPTH));
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_push      = i_wr_valid && !w_full;
    assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_head_op   = w_head[15:14];

    // Storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {i_wr_instr, i_wr_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_state        <= ST_IDLE;
            r_instr_out    <= BUBBLE;
            r_data_out     <= 8'h00;
            r_issue_valid  <= 1'b0;
            r_issued_count <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_state        <= w_state_next;
            r_instr_out    <= w_instr_next;
            r_data_out     <= w_data_next;
            r_issue_valid  <= w_valid_next;
            r_issued_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_instr_next = BUBBLE;
        w_data_next  = 8'h00;
        w_valid_next = 1'b0;
        w_count_next = r_issued_count;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !w_empty) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Running dry ends the run even while stalled.
                if (w_empty) begin
                    w_state_next = ST_IDLE;
                end else if (!i_stall) begin
                    w_pop = 1'b1;
                    if (w_head_op == OP_HALT) begin
                        w_state_next = ST_HALTED;
                    end else begin
                        w_instr_next = w_head[15:8];
                        w_data_next  = (w_head_op == OP_LOAD) ? w_head[7:0] : 8'h00;
                        w_valid_next = 1'b1;
                        w_count_next = r_issued_count + 8'd1;
                    end
                end
            end
            ST_HALTED: begin
                if (i_start) begin
                    w_state_next = w_empty ? ST_IDLE : ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_wr_ready     = !w_full;
    assign o_instr_out    = r_instr_out;
    assign o_data_out     = r_data_out;
    assign o_issue_valid  = r_issue_valid;
    assign o_issued_count = r_issued_count;
    assign o_busy         = (r_state == ST_RUN);
    assign o_halted       = (r_state == ST_HALTED);

endmodule
